// File: rtl/clock_pkg.sv
// Shared mode encodings and BCD helpers for the digital clock controller.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN      = 2'd0,
    MODE_SET_HOUR = 2'd1,
    MODE_SET_MIN  = 2'd2,
    MODE_UNUSED   = 2'd3
  } mode_e;

  localparam logic [3:0] BCD_5  = 4'd5;
  localparam logic [3:0] BCD_9  = 4'd9;
  localparam logic [7:0] BCD_59 = {BCD_5, BCD_9};

  // Invalid BCD digit pairs can never equal 8'h59, so they never produce a carry.
  function automatic logic is_59(input logic [3:0] h, input logic [3:0] l);
    return {h, l} == BCD_59;
  endfunction

endpackage

// File: rtl/key_sync.sv
// Two-flop synchronizer with a registered rising-edge pulse for a debounced key.
// All flops reset to 1 so that a key held through reset produces no pulse.
module key_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic level,
  output logic pulse
);

  logic meta;
  logic sync;
  logic hist;

  // The pulse lands on the third clock edge after the key rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b1;
      sync  <= 1'b1;
      hist  <= 1'b1;
      pulse <= 1'b0;
    end else begin
      meta  <= key;
      sync  <= meta;
      hist  <= sync;
      pulse <= sync & ~hist;
    end
  end

  assign level = sync;

endmodule

// File: rtl/clock_ctrl.sv
// Mode and carry controller: 1 Hz prescaler, RUN/SET mode FSM, adjust-key
// auto-repeat and blink generation driving the sec/min/hour counter enables.
module clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned HOLD_CYC  = 25000000,
  parameter int unsigned RPT_CYC   = 10000000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic       CP,
  input  logic       nreset,
  input  logic       mode_key,
  input  logic       adj_key,
  input  logic [3:0] sec_h,
  input  logic [3:0] sec_l,
  input  logic [3:0] min_h,
  input  logic [3:0] min_l,
  output logic       sec_en,
  output logic       min_en,
  output logic       hour_en,
  output logic       sec_clr,
  output logic [1:0] mode,
  output logic       blink,
  output logic       tick
);

  localparam int unsigned PW = $clog2(TICK_DIV + 1);
  localparam int unsigned RW = $clog2(HOLD_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] TICK_LAST  = PW'(TICK_DIV - 1);
  localparam logic [RW-1:0] HOLD_LAST  = RW'(HOLD_CYC);
  localparam logic [RW-1:0] RPT_START  = RW'(1);
  localparam logic [RW-1:0] RPT_RELOAD = RW'(HOLD_CYC - RPT_CYC + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  mode_e         state, state_nx;
  logic          sec_clr_nx;
  logic          transition;
  logic          set_mode;
  logic          mode_pulse, mode_level_unused;
  logic          adj_pulse, adj_level;
  logic          rpt_pulse, step;
  logic          sec59, min59;
  logic [PW-1:0] pre_cnt;
  logic [RW-1:0] rpt_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_q;

  key_sync u_mode_sync (
    .clk   (CP),
    .rst_n (nreset),
    .key   (mode_key),
    .level (mode_level_unused),
    .pulse (mode_pulse)
  );

  key_sync u_adj_sync (
    .clk   (CP),
    .rst_n (nreset),
    .key   (adj_key),
    .level (adj_level),
    .pulse (adj_pulse)
  );

  assign set_mode   = (state == MODE_SET_HOUR) || (state == MODE_SET_MIN);
  assign transition = (state_nx != state);
  assign tick       = (state == MODE_RUN) && (pre_cnt == TICK_LAST);
  assign rpt_pulse  = set_mode && adj_level && (rpt_cnt == HOLD_LAST);
  // A mode pulse in the same cycle swallows any adjust step.
  assign step       = set_mode && (adj_pulse || rpt_pulse) && !mode_pulse;
  assign sec59      = is_59(sec_h, sec_l);
  assign min59      = is_59(min_h, min_l);
  assign mode       = state;
  assign blink      = blink_q && set_mode;

  always_ff @(posedge CP or negedge nreset) begin
    if (!nreset) begin
      state   <= MODE_RUN;
      sec_clr <= 1'b0;
    end else begin
      state   <= state_nx;
      sec_clr <= sec_clr_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    sec_clr_nx = 1'b0;
    case (state)
      MODE_RUN:      if (mode_pulse) state_nx = MODE_SET_HOUR;
      MODE_SET_HOUR: if (mode_pulse) state_nx = MODE_SET_MIN;
      MODE_SET_MIN: begin
        if (mode_pulse) begin
          state_nx   = MODE_RUN;
          sec_clr_nx = 1'b1;
        end
      end
      default:       state_nx = MODE_RUN;
    endcase
  end

  always_comb begin
    sec_en  = 1'b0;
    min_en  = 1'b0;
    hour_en = 1'b0;
    case (state)
      MODE_RUN: begin
        sec_en  = tick;
        min_en  = tick && sec59;
        hour_en = tick && sec59 && min59;
      end
      MODE_SET_HOUR: hour_en = step;
      MODE_SET_MIN:  min_en  = step;
      default: ;
    endcase
  end

  // Holding the prescaler at 0 outside RUN gives a full first second on return.
  always_ff @(posedge CP or negedge nreset) begin
    if (!nreset)
      pre_cnt <= '0;
    else if (state != MODE_RUN)
      pre_cnt <= '0;
    else if (pre_cnt == TICK_LAST)
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + 1'b1;
  end

  // Counter starts at 1 on the edge pulse; reloading after each repeat spaces them by RPT_CYC.
  always_ff @(posedge CP or negedge nreset) begin
    if (!nreset)
      rpt_cnt <= '0;
    else if (transition || !set_mode || !adj_level)
      rpt_cnt <= '0;
    else if (adj_pulse)
      rpt_cnt <= RPT_START;
    else if (rpt_pulse)
      rpt_cnt <= RPT_RELOAD;
    else if (rpt_cnt != '0)
      rpt_cnt <= rpt_cnt + 1'b1;
  end

  always_ff @(posedge CP or negedge nreset) begin
    if (!nreset) begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end else if (transition) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (set_mode) begin
      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        blink_q   <= ~blink_q;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end else begin
      blink_cnt <= '0;
      blink_q   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_clock_ctrl.sv
// Self-checking bench for clock_ctrl: directed scenarios followed by random key
// and digit traffic, all compared against a time-based behavioural model.
module tb_clock_ctrl;

  localparam int TICK_DIV  = 4;
  localparam int HOLD_CYC  = 8;
  localparam int RPT_CYC   = 3;
  localparam int BLINK_DIV = 2;

  logic       CP = 1'b0;
  logic       nreset;
  logic       mode_key, adj_key;
  logic [3:0] sec_h, sec_l, min_h, min_l;
  logic       sec_en, min_en, hour_en, sec_clr, blink, tick;
  logic [1:0] mode;

  int checks = 0;
  int errors = 0;

  // Behavioural model: ages in cycles since the relevant event, key histories.
  int       m_mode;
  int       run_age;
  int       set_age;
  bit       rep_active;
  int       rep_age;
  bit       clr_pend;
  bit [4:0] mhist, ahist;

  int obs_ticks, obs_hour, obs_clr;

  clock_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .HOLD_CYC  (HOLD_CYC),
    .RPT_CYC   (RPT_CYC),
    .BLINK_DIV (BLINK_DIV)
  ) dut (
    .CP       (CP),
    .nreset   (nreset),
    .mode_key (mode_key),
    .adj_key  (adj_key),
    .sec_h    (sec_h),
    .sec_l    (sec_l),
    .min_h    (min_h),
    .min_l    (min_l),
    .sec_en   (sec_en),
    .min_en   (min_en),
    .hour_en  (hour_en),
    .sec_clr  (sec_clr),
    .mode     (mode),
    .blink    (blink),
    .tick     (tick)
  );

  always #5 CP = ~CP;

  task automatic checkOutput(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic resetModel();
    m_mode     = 0;
    run_age    = 0;
    set_age    = 0;
    rep_active = 1'b0;
    rep_age    = 0;
    clr_pend   = 1'b0;
    mhist      = '1;
    ahist      = '1;
  endtask

  // One clock cycle: drive inputs, check every output against the model, advance it.
  task automatic applyStimulus(input logic mk, input logic ak,
                               input logic [3:0] sh, input logic [3:0] sl,
                               input logic [3:0] mh, input logic [3:0] ml);
    bit mp, ap, al, set, e_tick, rep, stp, s59, m59;
    int e_sec, e_min, e_hour, e_blink, nm;
    mode_key = mk;
    adj_key  = ak;
    sec_h = sh; sec_l = sl; min_h = mh; min_l = ml;
    mhist = {mhist[3:0], mk};
    ahist = {ahist[3:0], ak};
    @(negedge CP);
    mp  = mhist[3] && !mhist[4];
    ap  = ahist[3] && !ahist[4];
    al  = ahist[2];
    set = (m_mode != 0);
    s59 = (sh == 4'd5) && (sl == 4'd9);
    m59 = (mh == 4'd5) && (ml == 4'd9);
    e_tick = (m_mode == 0) && (run_age % TICK_DIV == TICK_DIV - 1);
    rep = set && al && rep_active && rep_age >= HOLD_CYC &&
          ((rep_age - HOLD_CYC) % RPT_CYC == 0);
    stp = set && (ap || rep) && !mp;
    e_sec   = (m_mode == 0) ? int'(e_tick) : 0;
    e_min   = (m_mode == 0) ? int'(e_tick && s59) : (m_mode == 2 ? int'(stp) : 0);
    e_hour  = (m_mode == 0) ? int'(e_tick && s59 && m59) : (m_mode == 1 ? int'(stp) : 0);
    e_blink = (set && ((set_age / BLINK_DIV) % 2 == 0)) ? 1 : 0;
    checkOutput("tick", int'(tick), int'(e_tick));
    checkOutput("sec_en", int'(sec_en), e_sec);
    checkOutput("min_en", int'(min_en), e_min);
    checkOutput("hour_en", int'(hour_en), e_hour);
    checkOutput("sec_clr", int'(sec_clr), int'(clr_pend));
    checkOutput("mode", int'(mode), m_mode);
    checkOutput("blink", int'(blink), e_blink);
    obs_ticks += int'(tick);
    obs_hour  += int'(hour_en);
    obs_clr   += int'(sec_clr);
    nm       = mp ? (m_mode + 1) % 3 : m_mode;
    clr_pend = mp && (m_mode == 2);
    if (mp || !set || !al) rep_active = 1'b0;
    else if (ap) begin rep_active = 1'b1; rep_age = 1; end
    else if (rep_active) rep_age++;
    if (nm == 0) run_age = (m_mode == 0) ? run_age + 1 : 0;
    set_age = mp ? 0 : set_age + 1;
    m_mode  = nm;
    @(posedge CP);
    #1;
  endtask

  task automatic pressMode(input int low_cycles);
    applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (low_cycles) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
  endtask

  initial begin
    logic       mk_lvl, ak_lvl;
    logic [3:0] rsh, rsl, rmh, rml;
    nreset = 1'b0;
    mode_key = 1'b0; adj_key = 1'b0;
    sec_h = '0; sec_l = '0; min_h = '0; min_l = '0;
    obs_ticks = 0; obs_hour = 0; obs_clr = 0;
    resetModel();
    @(negedge CP);
    checkOutput("rst_mode", int'(mode), 0);
    checkOutput("rst_enables", int'({sec_en, min_en, hour_en, sec_clr, blink, tick}), 0);
    @(posedge CP);
    #1 nreset = 1'b1;

    // Plain running seconds
    repeat (12) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("first_12_ticks", obs_ticks, 3);

    // Full carry, then seconds-only carry
    repeat (4) applyStimulus(1'b0, 1'b0, 4'd5, 4'd9, 4'd5, 4'd9);
    repeat (4) applyStimulus(1'b0, 1'b0, 4'd5, 4'd9, 4'd1, 4'd2);
    repeat (4) applyStimulus(1'b0, 1'b0, 4'd15, 4'd9, 4'd5, 4'd9);

    // Mode cycling through both set modes back to RUN
    obs_clr = 0;
    pressMode(7);
    pressMode(7);
    pressMode(9);
    checkOutput("clr_count_cycle", obs_clr, 1);

    // Auto-repeat in SET_HOUR
    pressMode(5);
    obs_hour = 0;
    repeat (20) applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (10) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("hold_hour_steps", obs_hour, 5);

    // Simultaneous mode and adjust in SET_MIN
    pressMode(5);
    obs_clr = 0;
    applyStimulus(1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    repeat (7) applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("clr_count_simul", obs_clr, 1);
    checkOutput("mode_after_simul", int'(mode), 0);

    // Asynchronous reset mid SET_MIN with adjust held
    pressMode(5);
    pressMode(5);
    repeat (6) applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    #2 nreset = 1'b0;
    #1;
    checkOutput("async_rst_mode", int'(mode), 0);
    checkOutput("async_rst_outs", int'({sec_en, min_en, hour_en, sec_clr, blink, tick}), 0);
    resetModel();
    @(posedge CP);
    #1 nreset = 1'b1;
    obs_ticks = 0;
    obs_hour  = 0;
    repeat (3) applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);
    checkOutput("no_tick_before_4", obs_ticks, 0);
    repeat (5) applyStimulus(1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 4'd0);

    // Random key traffic and digit patterns
    mk_lvl = 1'b0;
    ak_lvl = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) mk_lvl = ~mk_lvl;
      if ($urandom_range(0, 19) == 0) ak_lvl = ~ak_lvl;
      rsh = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'($urandom_range(0, 15));
      rsl = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      rmh = ($urandom_range(0, 1) == 0) ? 4'd5 : 4'($urandom_range(0, 15));
      rml = ($urandom_range(0, 1) == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      applyStimulus(mk_lvl, ak_lvl, rsh, rsl, rmh, rml);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_ctrl.md
Name: clock_ctrl

Overview:
- Mode and carry controller for the digital clock. It sequences the seconds (mod-60), minutes (mod-60) and hours (mod-24, `counter_24`) BCD counters.
- In RUN mode it derives a 1 Hz tick from CP and produces cascaded one-cycle count enables.
- In the set modes it routes the adjust key (single step or auto-repeat) to the selected counter and freezes timekeeping.
- It sits between the debounced front-panel keys and the counter chain. All counters share CP.

Parameters:
- TICK_DIV, 50000000: CP cycles per 1 s tick.
- HOLD_CYC, 25000000: cycles adj_key must stay held after its rising edge before auto-repeat starts.
- RPT_CYC, 10000000: cycles between auto-repeat steps.
- BLINK_DIV, 12500000: cycles per blink half-period in set modes.

Ports:
- CP  input  1  system clock. All counters are clocked by CP.
- nreset  input  1  asynchronous, active-low reset.
- mode_key  input  1  debounced level, asynchronous to CP.
- adj_key  input  1  debounced level, asynchronous to CP.
- sec_h  input  4  seconds tens digit (BCD) from the seconds counter.
- sec_l  input  4  seconds units digit (BCD).
- min_h  input  4  minutes tens digit (BCD).
- min_l  input  4  minutes units digit (BCD).
- sec_en  output  1  one-cycle count enable for the seconds counter.
- min_en  output  1  one-cycle count enable for the minutes counter.
- hour_en  output  1  one-cycle count enable for `counter_24`.
- sec_clr  output  1  one-cycle synchronous clear request for the seconds counter.
- mode  output  2  0 = RUN, 1 = SET_HOUR, 2 = SET_MIN (3 unused).
- blink  output  1  display blink for the field being set.
- tick  output  1  1 Hz pulse, for display and debug.

Behaviour:
- Reset (nreset low, asynchronous):
  - FSM goes to RUN; prescaler, repeat and blink counters clear to 0.
  - All outputs are 0.
  - Key synchronizer and edge-history flops reset to 1, so a key held through reset gives no pulse.
- Keys:
  - Each key passes a 2-flop synchronizer and rising-edge detect.
  - The internal pulse asserts for exactly 1 cycle, on the 3rd CP edge after the key rises.
  - The pulse re-arms only after the key has been seen low.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps.
  - tick = 1 only while count == TICK_DIV-1, and only in RUN.
  - In SET_HOUR and SET_MIN the prescaler is held at 0, so the first second after returning to RUN is a full TICK_DIV cycles.
- Enables are combinational decodes of registered state and the counter inputs, with zero added latency.
- RUN:
  - sec_en = tick.
  - min_en = tick AND sec == 59.
  - hour_en = tick AND sec == 59 AND min == 59.
  - A digit pattern that is not valid BCD (e.g. sec_l > 9) never matches 59; the counters self-correct.
- FSM transitions, on each mode pulse: RUN -> SET_HOUR -> SET_MIN -> RUN.
  - On the SET_MIN -> RUN transition, sec_clr pulses 1 cycle (the cycle after the mode pulse).
  - Every transition clears the repeat counter and loads blink = 1.
  - Unused encoding 3 returns to RUN on the next cycle.
- Steps in the set modes:
  - step = adj pulse OR auto-repeat pulse.
  - SET_HOUR: hour_en = step; sec_en = min_en = 0.
  - SET_MIN: min_en = step, with no carry into hours (minutes wrap 59 -> 00 alone); sec_en = hour_en = 0.
- Auto-repeat:
  - While synced adj is high in a set mode, the repeat counter counts.
  - First repeat step at HOLD_CYC cycles after the edge pulse, then every RPT_CYC cycles.
  - adj low clears the counter.
  - Repeat pulses are one cycle wide and never coincide with the edge pulse.
- Simultaneous mode and adj pulse in one cycle: mode wins, the step is discarded.
- blink:
  - 0 in RUN.
  - In set modes it toggles every BLINK_DIV cycles, starting at 1 on entry.
- Mid-operation reset asynchronously aborts any set mode and drops all enables immediately.

Decomposition:
- Shared package clock_pkg:
  - mode encodings MODE_RUN = 2'd0, MODE_SET_HOUR = 2'd1, MODE_SET_MIN = 2'd2;
  - BCD constants for 5, 9 and 59;
  - helper function is_59(h, l).
- One sub-module: key_sync (2-flop synchronizer, reset-to-1, rising-edge pulse). Instantiated twice.
- Prescaler, FSM, repeat and blink logic stay in clock_ctrl.

Test Plan (TICK_DIV=4, HOLD_CYC=8, RPT_CYC=3, BLINK_DIV=2):
1. Release reset, sec=00, keys low, run 12 cycles -> tick and sec_en high on cycles 4, 8, 12 only; min_en = hour_en = 0; mode = 0.
2. Hold sec=59, min=59, run to next tick -> sec_en, min_en and hour_en all high in that same single cycle. With sec=59, min=12: only sec_en and min_en.
3. Pulse mode_key 3 times, each with the key low between -> mode 1, then 2, then 0. sec_clr high exactly 1 cycle after the third pulse. Prescaler restarts, so the first tick is 4 cycles after re-entering RUN. blink reads 1,1,0,0,1... in set modes.
4. In SET_HOUR, hold adj_key for 20 cycles -> hour_en at the edge pulse, then at +8, +11, +14, +17. min_en = sec_en = 0 throughout. Release adj -> no further pulses.
5. In SET_MIN, raise mode_key and adj_key in the same cycle -> mode goes to 0, min_en stays 0, sec_clr pulses once.
6. Assert nreset mid SET_MIN with adj held -> all outputs 0 asynchronously, mode = 0. After release with adj still high, no step pulse and no tick before cycle 4.
